// File: rtl/alu_sequencer.sv
// alu_sequencer: feeds registered operands and a one-hot opcode to an external
// combinational ALU for EXEC_CYCLES cycles, then presents the captured result.
module alu_sequencer #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_op1,
    input  logic [7:0] in_op2,
    input  logic [2:0] in_opcode,
    output logic [7:0] alu_op1,
    output logic [7:0] alu_op2,
    output logic [7:0] alu_d,
    input  logic [7:0] alu_ans,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_result,
    output logic [2:0] out_opcode,
    output logic       out_zero,
    output logic [7:0] op_count
);
    // Out-of-range cycle counts fall back to a single execute cycle.
    localparam logic [3:0] CYC_LAST = (EXEC_CYCLES >= 1 && EXEC_CYCLES <= 15) ? 4'(EXEC_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d, count_q, count_d;
    logic [2:0] opc_q, opc_d, res_opc_q, res_opc_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opc_d     = opc_q;
        res_d     = res_q;
        res_opc_d = res_opc_q;
        count_d   = count_q;
        case (state_q)
            IDLE: if (in_valid) begin
                op1_d   = in_op1;
                op2_d   = in_op2;
                opc_d   = in_opcode;
                cnt_d   = CYC_LAST;
                state_d = EXEC;
            end
            EXEC: if (cnt_q == 4'd0) begin
                res_d     = alu_ans;
                res_opc_d = opc_q;
                state_d   = DONE;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: if (out_ready) begin
                count_d = count_q + 8'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            opc_q     <= '0;
            res_q     <= '0;
            res_opc_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            opc_q     <= opc_d;
            res_q     <= res_d;
            res_opc_q <= res_opc_d;
            count_q   <= count_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign alu_d      = (state_q == EXEC) ? 8'h01 << opc_q : 8'h00;
    assign alu_op1    = op1_q;
    assign alu_op2    = op2_q;
    assign out_result = res_q;
    assign out_opcode = res_opc_q;
    assign out_zero   = res_q == 8'h00;
    assign op_count   = count_q;
endmodule
